// File: rtl/player_motion_ctl.sv
// player_motion_ctl: per-player position controller driven by frame ticks.
// x moves by STEP with clamping; y follows a GROUND/JUMP_UP/FALL FSM with
// integer gravity. Optional build macro: PLAYER_DOUBLE_JUMP_EN (one extra
// jump allowed while airborne).

package state_pkg;
    typedef enum logic [1:0] {
        START   = 2'd0,
        LEVEL_1 = 2'd1,
        FINISH  = 2'd2
    } g_state;
endpackage

module player_motion_ctl
    import state_pkg::*;
#(
    parameter int unsigned X_START  = 32,
    parameter int unsigned X_MIN    = 0,
    parameter int unsigned X_MAX    = 960,
    parameter int unsigned STEP     = 4,
    parameter int unsigned GROUND_Y = 600,
    parameter int unsigned Y_MIN    = 16,
    parameter int unsigned JUMP_V   = 12,
    parameter int unsigned GRAVITY  = 1,
    parameter int unsigned V_MAX    = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  g_state      game_state,
    input  logic        move_left,
    input  logic        move_right,
    input  logic        jump,
    output logic [11:0] xpos_player,
    output logic [11:0] ypos_player,
    output logic        airborne
);

    typedef enum logic [1:0] {
        GROUND  = 2'd0,
        JUMP_UP = 2'd1,
        FALL    = 2'd2
    } motion_e;

    localparam logic [12:0] X_START_C  = 13'(X_START);
    localparam logic [12:0] X_MIN_C    = 13'(X_MIN);
    localparam logic [12:0] X_MAX_C    = 13'(X_MAX);
    localparam logic [12:0] STEP_C     = 13'(STEP);
    localparam logic [12:0] GROUND_Y_C = 13'(GROUND_Y);
    localparam logic [12:0] Y_MIN_C    = 13'(Y_MIN);
    localparam logic [5:0]  JUMP_V_C   = 6'(JUMP_V);
    localparam logic [5:0]  GRAVITY_C  = 6'(GRAVITY);
    localparam logic [6:0]  V_MAX_C    = 7'(V_MAX);

    motion_e     state_q, state_d;
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic [5:0]  vel_q, vel_d;
    logic        jump_prev_q, jump_prev_d;
    logic        pending_q, pending_d;
    logic        airborne_q, airborne_d;
    logic        dj_take;

`ifdef PLAYER_DOUBLE_JUMP_EN
    logic        double_q, double_d;
`endif

    // 13-bit working values so left moves and ascent cannot wrap
    logic [12:0] x13, y13, x_dn, x_up, y_up, y_fall;
    logic [6:0]  vel_sum, vel_fall;

    // State register: all motion flops, asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= GROUND;
            x_q         <= X_START_C[11:0];
            y_q         <= GROUND_Y_C[11:0];
            vel_q       <= '0;
            jump_prev_q <= 1'b0;
            pending_q   <= 1'b0;
            airborne_q  <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
            double_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            vel_q       <= vel_d;
            jump_prev_q <= jump_prev_d;
            pending_q   <= pending_d;
            airborne_q  <= airborne_d;
`ifdef PLAYER_DOUBLE_JUMP_EN
            double_q    <= double_d;
`endif
        end
    end

    // Next-state: level reset, jump edge capture, per-tick x and y motion
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        vel_d       = vel_q;
        pending_d   = pending_q;
        jump_prev_d = jump;
        dj_take     = 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
        double_d    = double_q;
        dj_take     = pending_q && !double_q;
`endif
        x13      = {1'b0, x_q};
        y13      = {1'b0, y_q};
        x_dn     = x13 - STEP_C;
        x_up     = x13 + STEP_C;
        y_up     = y13 - {7'd0, vel_q};
        vel_sum  = {1'b0, vel_q} + {1'b0, GRAVITY_C};
        vel_fall = (vel_sum > V_MAX_C) ? V_MAX_C : vel_sum;
        y_fall   = y13 + {6'd0, vel_fall};

        if (game_state != LEVEL_1) begin
            x_d       = X_START_C[11:0];
            y_d       = GROUND_Y_C[11:0];
            state_d   = GROUND;
            vel_d     = '0;
            pending_d = 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
            double_d  = 1'b0;
`endif
        end else begin
            // an edge coinciding with a tick is kept for the following tick
            if (jump && !jump_prev_q)
                pending_d = 1'b1;
            else if (frame_tick)
                pending_d = 1'b0;

            if (frame_tick) begin
                if (move_left && !move_right)
                    x_d = (x_dn[12] || x_dn < X_MIN_C) ? X_MIN_C[11:0] : x_dn[11:0];
                else if (move_right && !move_left)
                    x_d = (x_up > X_MAX_C) ? X_MAX_C[11:0] : x_up[11:0];

                if (dj_take && state_q != GROUND) begin
                    vel_d   = JUMP_V_C;
                    state_d = JUMP_UP;
`ifdef PLAYER_DOUBLE_JUMP_EN
                    double_d = 1'b1;
`endif
                end else begin
                    case (state_q)
                        GROUND: begin
`ifdef PLAYER_DOUBLE_JUMP_EN
                            double_d = 1'b0;
`endif
                            if (pending_q) begin
                                vel_d   = JUMP_V_C;
                                state_d = JUMP_UP;
                            end
                        end
                        JUMP_UP: begin
                            if (y13 <= Y_MIN_C + {7'd0, vel_q}) begin
                                y_d     = Y_MIN_C[11:0];
                                vel_d   = '0;
                                state_d = FALL;
                            end else begin
                                y_d = y_up[11:0];
                                if (GRAVITY_C >= vel_q) begin
                                    vel_d   = '0;
                                    state_d = FALL;
                                end else begin
                                    vel_d = vel_q - GRAVITY_C;
                                end
                            end
                        end
                        FALL: begin
                            if (y_fall >= GROUND_Y_C) begin
                                y_d     = GROUND_Y_C[11:0];
                                vel_d   = '0;
                                state_d = GROUND;
`ifdef PLAYER_DOUBLE_JUMP_EN
                                double_d = 1'b0;
`endif
                            end else begin
                                y_d   = y_fall[11:0];
                                vel_d = vel_fall[5:0];
                            end
                        end
                        default: begin
                            state_d = GROUND;
                            vel_d   = '0;
                        end
                    endcase
                end
            end
        end

        airborne_d = (state_d != GROUND);
    end

    assign xpos_player = x_q;
    assign ypos_player = y_q;
    assign airborne    = airborne_q;

endmodule

// File: tb/tb_player_motion_ctl.sv
// Directed bench for player_motion_ctl with hand-computed expected positions.
// Double-jump expectations follow PLAYER_DOUBLE_JUMP_EN when defined.

module tb_player_motion_ctl;
    import state_pkg::*;

    logic        clk;
    logic        rst;
    logic        frame_tick;
    g_state      game_state;
    logic        move_left;
    logic        move_right;
    logic        jump;
    logic [11:0] xpos_player;
    logic [11:0] ypos_player;
    logic        airborne;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned launches;
    int unsigned land_ticks;
    logic        prev_air;

    player_motion_ctl dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .game_state  (game_state),
        .move_left   (move_left),
        .move_right  (move_right),
        .jump        (jump),
        .xpos_player (xpos_player),
        .ypos_player (ypos_player),
        .airborne    (airborne)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // one frame tick; returns at the following negedge with outputs updated
    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_jump();
        @(negedge clk);
        jump = 1'b1;
        @(negedge clk);
        jump = 1'b0;
    endtask

    task automatic restart_level();
        @(negedge clk);
        game_state = START;
        @(negedge clk);
        game_state = LEVEL_1;
    endtask

    initial begin
        rst        = 1'b0;
        frame_tick = 1'b0;
        game_state = LEVEL_1;
        move_left  = 1'b0;
        move_right = 1'b0;
        jump       = 1'b0;

        // reset state
        #12;
        check("rst_x", 32'(xpos_player), 32);
        check("rst_y", 32'(ypos_player), 600);
        check("rst_air", 32'(airborne), 0);
        @(negedge clk);
        rst = 1'b1;
        ticks(10);
        check("idle_x", 32'(xpos_player), 32);
        check("idle_y", 32'(ypos_player), 600);

        // right moves and right clamp
        move_right = 1'b1;
        tick();
        check("right_t1", 32'(xpos_player), 36);
        ticks(230);
        check("right_t231", 32'(xpos_player), 956);
        tick();
        check("right_t232", 32'(xpos_player), 960);
        ticks(8);
        check("right_t240", 32'(xpos_player), 960);
        // no change on non-tick cycles
        @(negedge clk);
        move_right = 1'b0;
        restart_level();
        move_right = 1'b1;
        repeat (5) @(negedge clk);
        check("no_tick_x", 32'(xpos_player), 32);
        move_right = 1'b0;

        // left moves and left clamp (no wrap)
        move_left = 1'b1;
        ticks(7);
        check("left_t7", 32'(xpos_player), 4);
        tick();
        check("left_t8", 32'(xpos_player), 0);
        tick();
        check("left_t9", 32'(xpos_player), 0);
        move_left = 1'b0;

        // both inputs held: x constant
        move_right = 1'b1;
        ticks(5);
        check("pre_both_x", 32'(xpos_player), 20);
        move_left = 1'b1;
        ticks(5);
        check("both_x", 32'(xpos_player), 20);
        move_left  = 1'b0;
        move_right = 1'b0;

        // single jump: launch tick, then 24 motion ticks
        pulse_jump();
        tick();
        check("launch_y", 32'(ypos_player), 600);
        check("launch_air", 32'(airborne), 1);
        tick();
        check("jump_t1", 32'(ypos_player), 588);
        ticks(10);
        check("jump_t11", 32'(ypos_player), 523);
        tick();
        check("jump_t12_apex", 32'(ypos_player), 522);
        tick();
        check("jump_t13", 32'(ypos_player), 523);
        ticks(10);
        check("jump_t23", 32'(ypos_player), 588);
        check("jump_t23_air", 32'(airborne), 1);
        tick();
        check("jump_t24_land", 32'(ypos_player), 600);
        check("jump_t24_air", 32'(airborne), 0);
        tick();
        check("jump_t25", 32'(ypos_player), 600);
        check("jump_x_kept", 32'(xpos_player), 20);

        // held jump triggers once
        @(negedge clk);
        jump     = 1'b1;
        launches = 0;
        prev_air = 1'b0;
        for (int unsigned i = 0; i < 50; i++) begin
            tick();
            if (airborne && !prev_air) launches++;
            prev_air = airborne;
        end
        check("held_launches", launches, 1);
        check("held_y", 32'(ypos_player), 600);
        check("held_air", 32'(airborne), 0);
        @(negedge clk);
        jump = 1'b0;

        // leaving LEVEL_1 mid-jump
        move_right = 1'b1;
        pulse_jump();
        ticks(13);
        check("mid_y", 32'(ypos_player), 522);
        check("mid_x", 32'(xpos_player), 72);
        move_right = 1'b0;
        @(negedge clk);
        game_state = FINISH;
        @(negedge clk);
        check("finish_x", 32'(xpos_player), 32);
        check("finish_y", 32'(ypos_player), 600);
        check("finish_air", 32'(airborne), 0);
        game_state = START;
        pulse_jump();
        tick();
        @(negedge clk);
        game_state = LEVEL_1;
        ticks(2);
        check("start_jump_y", 32'(ypos_player), 600);
        check("start_jump_air", 32'(airborne), 0);

        // double jump at apex
        pulse_jump();
        ticks(13);
        check("dj_apex1", 32'(ypos_player), 522);
        pulse_jump();
        tick();
`ifdef PLAYER_DOUBLE_JUMP_EN
        check("dj_relaunch_y", 32'(ypos_player), 522);
        ticks(12);
        check("dj_apex2", 32'(ypos_player), 444);
        pulse_jump();
        tick();
        check("dj_third_ignored", 32'(ypos_player), 445);
`else
        check("dj_second_ignored", 32'(ypos_player), 523);
        pulse_jump();
        tick();
        check("dj_third_ignored", 32'(ypos_player), 525);
`endif
        land_ticks = 0;
        while (airborne && land_ticks < 40) begin
            tick();
            land_ticks++;
        end
        check("dj_land_timeout", 32'(airborne), 0);
        check("dj_land_y", 32'(ypos_player), 600);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
